// File: rtl/packer_sequencer_pkg.sv
// Shared constants and state type for the activation packer and its layer sequencer.
package packer_sequencer_pkg;

  localparam int unsigned WORDS_PER_GROUP = 16;
  localparam int unsigned WORD_IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ENC  = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_PACK = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/packer_sequencer.sv
// Layer sequencer: hands encoder words to the packer one at a time, counts groups of
// 16 words and maps packer write strobes/offsets onto absolute SRAM enables and addresses.
module packer_sequencer
  import packer_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_ACT   = 14,
  parameter int unsigned ADDR_WIDTH_MASKS = 11,
  parameter int unsigned GROUP_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        start,
  input  logic [GROUP_CNT_WIDTH-1:0]  num_groups,
  input  logic [ADDR_WIDTH_ACT-1:0]   act_base,
  input  logic [ADDR_WIDTH_MASKS-1:0] mask_base,
  input  logic                        enc_valid,
  output logic                        enc_pop,
  output logic                        start_packer,
  output logic [3:0]                  encoder_to_packer_counter,
  input  logic                        ready_packer,
  input  logic                        packer_write_control,
  input  logic                        write_activations_memory_extra,
  input  logic                        write_masks_memory_extra,
  input  logic [ADDR_WIDTH_ACT-1:0]   outputs_encoded_to_memory_counter,
  input  logic [ADDR_WIDTH_MASKS-1:0] outputs_masks_to_memory_counter,
  output logic                        act_we,
  output logic [ADDR_WIDTH_ACT-1:0]   act_addr,
  output logic                        mask_we,
  output logic [ADDR_WIDTH_MASKS-1:0] mask_addr,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH_ACT:0]     act_words_written
);

  localparam logic [WORD_IDX_W-1:0]      LAST_WORD = WORD_IDX_W'(WORDS_PER_GROUP - 1);
  localparam logic [GROUP_CNT_WIDTH-1:0] GROUP_ONE = GROUP_CNT_WIDTH'(1);
  localparam logic [WORD_IDX_W-1:0]      IDX_ONE   = WORD_IDX_W'(1);

  seq_state_e                  state_q, state_d;
  logic [WORD_IDX_W-1:0]       word_idx_q, word_idx_d;
  logic [GROUP_CNT_WIDTH-1:0]  group_cnt_q, group_cnt_d;
  logic [GROUP_CNT_WIDTH-1:0]  num_groups_q, num_groups_d;
  logic [ADDR_WIDTH_ACT-1:0]   act_base_q, act_base_d;
  logic [ADDR_WIDTH_MASKS-1:0] mask_base_q, mask_base_d;
  logic [ADDR_WIDTH_ACT:0]     act_words_q, act_words_d;
  logic [GROUP_CNT_WIDTH-1:0]  group_cnt_inc;

  assign group_cnt_inc = group_cnt_q + GROUP_ONE;

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    group_cnt_d  = group_cnt_q;
    num_groups_d = num_groups_q;
    act_base_d   = act_base_q;
    mask_base_d  = mask_base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_groups_d = num_groups;
          act_base_d   = act_base;
          mask_base_d  = mask_base;
          word_idx_d   = '0;
          group_cnt_d  = '0;
          state_d      = (num_groups == '0) ? ST_DONE : ST_WAIT_ENC;
        end
      end
      ST_WAIT_ENC: begin
        if (enc_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_PACK;
      ST_WAIT_PACK: begin
        if (ready_packer) begin
          word_idx_d = word_idx_q + IDX_ONE;
          state_d    = ST_WAIT_ENC;
          // group boundary: the last word of a group closes it and may end the layer
          if (word_idx_q == LAST_WORD) begin
            group_cnt_d = group_cnt_inc;
            if (group_cnt_inc == num_groups_q) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign act_we   = packer_write_control & ~write_activations_memory_extra;
  assign mask_we  = packer_write_control & ~write_masks_memory_extra;
  assign act_addr = act_base_q + outputs_encoded_to_memory_counter;
  assign mask_addr = mask_base_q + outputs_masks_to_memory_counter;

  // layer start clears the write count even if a stray write lands in the same cycle
  always_comb begin
    act_words_d = act_words_q;
    if (state_q == ST_IDLE && start) begin
      act_words_d = '0;
    end else if (act_we && !(&act_words_q)) begin
      act_words_d = act_words_q + (ADDR_WIDTH_ACT + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= ST_IDLE;
      word_idx_q   <= '0;
      group_cnt_q  <= '0;
      num_groups_q <= '0;
      act_base_q   <= '0;
      mask_base_q  <= '0;
      act_words_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      group_cnt_q  <= group_cnt_d;
      num_groups_q <= num_groups_d;
      act_base_q   <= act_base_d;
      mask_base_q  <= mask_base_d;
      act_words_q  <= act_words_d;
    end
  end

  assign start_packer              = (state_q == ST_ISSUE);
  assign enc_pop                   = (state_q == ST_WAIT_PACK) & ready_packer;
  assign encoder_to_packer_counter = word_idx_q;
  assign busy                      = (state_q != ST_IDLE);
  assign done                      = (state_q == ST_DONE);
  assign act_words_written         = act_words_q;

endmodule
